// File: rtl/n1_pkg.sv
// Shared constants and enums for the n1 RAM arbiter.
package n1_pkg;
  localparam int unsigned N1_RAM_SIZE  = 128;
  localparam int unsigned N1_ADDR_BITS = $clog2(N1_RAM_SIZE);
  localparam int unsigned N1_DATA_W    = 16;

  typedef enum logic [1:0] {OWN_NONE, OWN_HOST, OWN_DATA, OWN_FETCH} owner_e;
  typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_DRAIN} state_e;
endpackage

// File: rtl/n1_prio_pick.sv
// Three-way priority picker: host > data > fetch, with an aged fetch
// allowed to jump ahead of data (never ahead of host).
module n1_prio_pick
  import n1_pkg::*;
(
  input  logic   host_req_i,
  input  logic   data_req_i,
  input  logic   fetch_req_i,
  input  logic   fetch_aged_i,
  output owner_e owner_o
);
  always_comb begin
    owner_o = OWN_NONE;
    if (host_req_i)                      owner_o = OWN_HOST;
    else if (fetch_req_i && fetch_aged_i) owner_o = OWN_FETCH;
    else if (data_req_i)                 owner_o = OWN_DATA;
    else if (fetch_req_i)                owner_o = OWN_FETCH;
  end
endmodule

// File: rtl/n1_mem_arbiter.sv
// Single-port RAM arbiter/sequencer for host loader, CPU data and fetch.
// Optional fetch aging is enabled with `define N1_ARB_FETCH_AGING_EN.
module n1_mem_arbiter
  import n1_pkg::*;
#(
  parameter int unsigned RAM_SIZE  = N1_RAM_SIZE,
  parameter int unsigned ADDR_BITS = $clog2(RAM_SIZE),
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 host_lock,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [N1_DATA_W-1:0] host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  input  logic                 data_req,
  input  logic                 data_we,
  input  logic [ADDR_BITS-1:0] data_addr,
  input  logic [N1_DATA_W-1:0] data_wdata,
  output logic                 data_gnt,
  output logic                 data_rvalid,
  input  logic                 fetch_req,
  input  logic [ADDR_BITS-1:0] fetch_addr,
  output logic                 fetch_gnt,
  output logic                 fetch_rvalid,
  output logic [N1_DATA_W-1:0] rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [N1_DATA_W-1:0] mem_wdata,
  input  logic [N1_DATA_W-1:0] mem_rdata,
  output logic                 cpu_hold
);
  state_e                 state_q, state_d;
  owner_e                 owner_q, owner_d, pick;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [N1_DATA_W-1:0]   wdata_q, wdata_d;
  logic                   host_ok, cpu_ok, fetch_aged;

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  assign host_ok = rst_n && (state_q != ST_DRAIN);
  assign cpu_ok  = rst_n && (state_q == ST_RUN) && !host_lock;

  n1_prio_pick u_pick (
    .host_req_i  (host_req  && host_ok),
    .data_req_i  (data_req  && cpu_ok),
    .fetch_req_i (fetch_req && cpu_ok),
    .fetch_aged_i(fetch_aged),
    .owner_o     (pick)
  );

  always_comb begin
    host_gnt  = (pick == OWN_HOST);
    data_gnt  = (pick == OWN_DATA);
    fetch_gnt = (pick == OWN_FETCH);
    mem_en    = (pick != OWN_NONE);
    mem_we    = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    owner_d   = OWN_NONE;
    unique case (pick)
      OWN_HOST: begin
        addr_d = host_addr;
        mem_we = host_we;
        if (host_we) wdata_d = host_wdata;
      end
      OWN_DATA: begin
        addr_d = data_addr;
        mem_we = data_we;
        if (data_we) wdata_d = data_wdata;
      end
      OWN_FETCH: addr_d = fetch_addr;
      default: ;
    endcase
    if (mem_en && !mem_we) owner_d = pick;
  end

  assign mem_addr  = addr_d;
  assign mem_wdata = wdata_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (host_lock) state_d = ST_LOAD;
      ST_LOAD:  if (!host_lock) state_d = ST_DRAIN;
      ST_DRAIN: state_d = host_lock ? ST_LOAD : ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  assign cpu_hold = rst_n && ((state_q != ST_RUN) || host_lock);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      owner_q <= OWN_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Read data returns one cycle after the grant; the owner tag steers it.
  assign host_rvalid  = (owner_q == OWN_HOST);
  assign data_rvalid  = (owner_q == OWN_DATA);
  assign fetch_rvalid = (owner_q == OWN_FETCH);
  assign rdata        = (owner_q != OWN_NONE) ? mem_rdata : '0;

`ifdef N1_ARB_FETCH_AGING_EN
  localparam int unsigned AGE_W = $clog2(MAX_WAIT + 1);
  logic [AGE_W-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (!fetch_req || fetch_gnt)          age_d = '0;
    else if (age_q != AGE_W'(MAX_WAIT))   age_d = age_q + AGE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) age_q <= '0;
    else        age_q <= age_d;
  end

  assign fetch_aged = (age_q == AGE_W'(MAX_WAIT));
`else
  assign fetch_aged = 1'b0;
`endif
endmodule

// File: tb/tb_n1_mem_arbiter.sv
// Self-checking bench for n1_mem_arbiter: vector table, directed corners, random vs model.
module tb_n1_mem_arbiter;
  localparam int RAM_SIZE = 128;
  localparam int AW       = 7;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          host_lock, host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr, data_addr, fetch_addr, mem_addr;
  logic [15:0]   host_wdata, data_wdata, rdata, mem_wdata;
  logic          data_req, data_we, data_gnt, data_rvalid;
  logic          fetch_req, fetch_gnt, fetch_rvalid;
  logic          mem_en, mem_we, cpu_hold;
  logic [15:0]   mem_rdata = 16'h0;
  logic [15:0]   ram [RAM_SIZE] = '{default: 16'h0};
  logic [15:0]   shadow [RAM_SIZE];
  int            n_cmp = 0, n_err = 0;

  typedef struct packed {
    logic [5:0] in;   // {lock, hreq, hwe, dreq, dwe, freq}
    logic [5:0] exp;  // {host_gnt, data_gnt, fetch_gnt, cpu_hold, mem_en, mem_we}
  } vec_t;
  vec_t tbl [19];

  always #5 clk = ~clk;

  n1_mem_arbiter #(.RAM_SIZE(RAM_SIZE), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .host_lock(host_lock),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold)
  );

  // Synchronous single-port RAM behind the arbiter
  always @(posedge clk) if (mem_en) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else        mem_rdata     <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return 64'({host_gnt, host_rvalid, data_gnt, data_rvalid, fetch_gnt, fetch_rvalid,
                cpu_hold, mem_en, mem_we, rdata, mem_addr, mem_wdata});
  endfunction

  function automatic logic [63:0] ctl();
    return 64'({host_gnt, data_gnt, fetch_gnt, cpu_hold, mem_en, mem_we});
  endfunction

  function automatic logic [63:0] rv();
    return 64'({host_rvalid, data_rvalid, fetch_rvalid});
  endfunction

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    host_req = 0; host_we = 0; data_req = 0; data_we = 0; fetch_req = 0;
  endtask

  initial begin
    int first;
    int m_wait, p_own;
    logic m_load, m_drain, e_h, e_d, e_f, e_we, cpu_ok, aged;
    logic h_done, d_done, f_done;
    logic [AW-1:0] a;
    logic [15:0] w, p_data;

    tbl = '{
      '{6'b000000, 6'b000000}, '{6'b000001, 6'b001010}, '{6'b000101, 6'b010010},
      '{6'b000110, 6'b010011}, '{6'b010101, 6'b100010}, '{6'b011000, 6'b100011},
      '{6'b011111, 6'b100011}, '{6'b000001, 6'b001010}, '{6'b100101, 6'b000100},
      '{6'b110101, 6'b100110}, '{6'b000101, 6'b000100}, '{6'b010101, 6'b000100},
      '{6'b000001, 6'b001010}, '{6'b111000, 6'b100111}, '{6'b010000, 6'b100110},
      '{6'b100101, 6'b000100}, '{6'b000000, 6'b000100}, '{6'b000000, 6'b000100},
      '{6'b000100, 6'b010010}};
    for (int i = 0; i < RAM_SIZE; i++) shadow[i] = 16'h0;

    rst_n = 0; host_lock = 0; idle();
    host_addr = '0; data_addr = '0; fetch_addr = '0; host_wdata = '0; data_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", all_out(), 64'h0);
    next();
    rst_n = 1;

    // Vector table: one row per cycle, FSM walks RUN/LOAD/DRAIN through the rows
    for (int i = 0; i < 19; i++) begin
      {host_lock, host_req, host_we, data_req, data_we, fetch_req} = tbl[i].in;
      host_addr = AW'(i); data_addr = AW'(i + 32); fetch_addr = AW'(i + 64);
      host_wdata = 16'hB000 + 16'(i); data_wdata = 16'hD000 + 16'(i);
      @(negedge clk);
      chk($sformatf("tbl%0d", i), ctl(), 64'(tbl[i].exp));
      if (tbl[i].exp[1] && tbl[i].exp[0]) begin
        if (tbl[i].exp[5]) shadow[i] = 16'hB000 + 16'(i);
        else if (tbl[i].exp[4]) shadow[i + 32] = 16'hD000 + 16'(i);
      end
      next();
    end
    host_lock = 0; idle(); next(); next();

    // Load session with data_req held; host reads back in the last LOAD cycle
    host_lock = 1; host_req = 1; host_we = 1; host_addr = 3; host_wdata = 16'hA5A5;
    data_req = 1; data_we = 0; data_addr = 9;
    @(negedge clk); chk("load_c0", ctl(), 64'b100111); shadow[3] = 16'hA5A5; next();
    host_addr = 9; host_wdata = 16'h1234;
    @(negedge clk); chk("load_c1", ctl(), 64'b100111); shadow[9] = 16'h1234; next();
    host_lock = 0; host_we = 0; host_addr = 3;
    @(negedge clk); chk("load_lastrd", ctl(), 64'b100110); next();
    host_req = 0;
    @(negedge clk);
    chk("drain_ctl", ctl(), 64'b000100);
    chk("drain_rv", rv(), 64'b100);
    chk("drain_rdata", 64'(rdata), 64'h A5A5);
    next();
    @(negedge clk); chk("run_data", ctl(), 64'b010010); chk("run_addr", 64'(mem_addr), 64'd9); next();
    data_req = 0;
    @(negedge clk); chk("run_data_rv", rv(), 64'b010); chk("run_data_rd", 64'(rdata), 64'h1234); next();

    // Data and fetch contend: data first, fetch next cycle
    data_req = 1; data_addr = 9; fetch_req = 1; fetch_addr = 7;
    @(negedge clk); chk("cont_c0", ctl(), 64'b010010); next();
    data_req = 0;
    @(negedge clk);
    chk("cont_c1", ctl(), 64'b001010);
    chk("cont_c1_rv", rv(), 64'b010);
    chk("cont_c1_rd", 64'(rdata), 64'h1234);
    next();
    fetch_req = 0;
    @(negedge clk); chk("cont_c2_rv", rv(), 64'b001); chk("cont_c2_rd", 64'(rdata), 64'(shadow[7])); next();

    // Reset the cycle after a fetch grant: the pending rvalid is discarded
    fetch_req = 1; fetch_addr = 5;
    @(negedge clk); chk("mid_gnt", ctl(), 64'b001010); next();
    rst_n = 0; fetch_req = 0;
    #1 chk("mid_rst_now", all_out(), 64'h0);
    @(negedge clk); chk("mid_rst_hold", all_out(), 64'h0);
    next(); next();
    rst_n = 1;
    @(negedge clk); chk("post_rst", all_out(), 64'h0); next();

    // Fetch held against a continuously requesting data port
    data_req = 1; data_we = 0; data_addr = 1; fetch_req = 1; fetch_addr = 2; first = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      f_done = fetch_gnt;
      if (fetch_gnt && first < 0) first = c;
      next();
      if (f_done) fetch_req = 0;
    end
`ifdef N1_ARB_FETCH_AGING_EN
    chk("aging_first", 64'(first), 64'(4));
`else
    chk("aging_first", 64'(first), 64'(-1));
`endif
    idle(); next(); next();

    // Randomized traffic against a rule-level model
    m_load = 0; m_drain = 0; m_wait = 0; p_own = 0; p_data = '0;
    h_done = 0; d_done = 0; f_done = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (h_done) host_req = 0;
      if (d_done) data_req = 0;
      if (f_done) fetch_req = 0;
      if (!host_req && $urandom_range(0, 3) == 0) begin
        host_req = 1; host_we = 1'($urandom); host_addr = AW'($urandom); host_wdata = 16'($urandom);
      end
      if (!data_req && $urandom_range(0, 1) == 0) begin
        data_req = 1; data_we = 1'($urandom); data_addr = AW'($urandom); data_wdata = 16'($urandom);
      end
      if (!fetch_req && $urandom_range(0, 1) == 0) begin
        fetch_req = 1; fetch_addr = AW'($urandom);
      end
      if ($urandom_range(0, 15) == 0) host_lock = !host_lock;
      @(negedge clk);

`ifdef N1_ARB_FETCH_AGING_EN
      aged = (m_wait >= MAX_WAIT);
`else
      aged = 1'b0;
`endif
      cpu_ok = !m_load && !m_drain && !host_lock;
      e_h  = host_req && !m_drain;
      e_f  = !e_h && cpu_ok && fetch_req && (aged || !data_req);
      e_d  = !e_h && cpu_ok && data_req && !e_f;
      e_we = (e_h && host_we) || (e_d && data_we);
      chk("rnd_ctl", ctl(), 64'({e_h, e_d, e_f, m_load || m_drain || host_lock, e_h || e_d || e_f, e_we}));
      chk("rnd_rv", rv(), 64'({p_own == 1, p_own == 2, p_own == 3}));
      if (p_own != 0) chk("rnd_rdata", 64'(rdata), 64'(p_data));
      if (e_h || e_d || e_f) begin
        a = e_h ? host_addr : (e_d ? data_addr : fetch_addr);
        chk("rnd_addr", 64'(mem_addr), 64'(a));
        if (e_we) begin
          w = e_h ? host_wdata : data_wdata;
          chk("rnd_wdata", 64'(mem_wdata), 64'(w));
          shadow[a] = w;
          p_own = 0;
        end else begin
          p_own = e_h ? 1 : (e_d ? 2 : 3);
          p_data = shadow[a];
        end
      end else p_own = 0;
      if (fetch_req && !e_f) m_wait++; else m_wait = 0;
      if (m_drain) begin m_drain = 0; m_load = host_lock; end
      else if (m_load) begin if (!host_lock) begin m_load = 0; m_drain = 1; end end
      else m_load = host_lock;

      h_done = host_gnt; d_done = data_gnt; f_done = fetch_gnt;
      next();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
